ddr_cmd_driver: RTL
===================

Name: ddr_cmd_driver

Overview:
- Controller-side command generator for the DDR4 interface. It is the initiator that drives the ACT/CAS/PRE pin traffic that the DIMM model samples and decodes.
- It accepts one transaction at a time over a valid/ready request port. Each transaction carries a read/write flag, a 19-bit row address, a 10-bit column address and the burst length.
- For each transaction it issues ACT, then RD or WR, then PRE, honouring the programmed timing gaps.
- It also produces the data-path timing strobes: write-data launch and read-data expect.

Parameters:
- T_RCD, 4: cycles from ACT to CAS.
- T_CL, 11: read CAS latency.
- T_CWL, 9: write CAS latency.
- T_WR, 12: write recovery, counted from the end of the write burst to PRE.
- T_RTP, 6: read CAS to PRE.
- T_RAS, 28: minimum cycles from ACT to PRE.
- T_RP, 4: cycles from PRE to the next request being accepted.
- CNT_W, 8: width of internal timing counters.

Ports:
- clock_t  in  1  Single clock; all logic on posedge.
- reset_n  in  1  Asynchronous, active-low reset.
- req_valid  in  1  Request present.
- req_ready  out  1  Block can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_row  in  19  {bg[1:0], ba[1:0], row[14:0]}.
- req_col  in  10  Column address.
- req_bl8  in  1  1 = BL8, 0 = BC4.
- cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14  out  1 each  Command pins.
- bg_addr  out  2  Bank group.
- ba_addr  out  2  Bank address.
- addr13, bc_n_a12, addr11, ap_a10  out  1 each  Address pins.
- addr9_0  out  10  Address pins.
- wdata_go  out  1  One-cycle pulse: DQ/DQS write burst starts next cycle.
- rdata_exp  out  1  One-cycle pulse: read data due on the bus.
- busy  out  1  Transaction in flight (inverse of req_ready outside reset).

Behaviour:
- All outputs are registered.
- Reset (async assert): state = IDLE; command pins = DES (cs_n=1, act_n=1, ras/cas/we=1); all address pins 0; req_ready=0; busy=0; wdata_go=0; rdata_exp=0. req_ready rises on the first clock edge after reset_n deasserts.
- Command encoding {cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14}:
  - ACT = 00 followed by row[16:14] on the ras/cas/we pins.
  - WR = 01100.
  - RD = 01101.
  - PRE = 01010.
  - DES = 1 followed by 1111.
- Address field mapping:
  - ACT: {bg, ba} = req_row[18:15]; {we_n_a14, addr13, bc_n_a12, addr11, ap_a10, addr9_0} = req_row[14:0].
  - CAS: addr9_0 = col; bc_n_a12 = bl8; ap_a10 = 0; bg/ba as for ACT; other address pins 0.
  - PRE: bg/ba driven; ap_a10 = 0 (single-bank precharge).
- Handshake: a transfer occurs when req_valid && req_ready are both high on a clock edge. All request fields are latched on that edge. req_ready drops on the following cycle. Inputs are ignored while req_ready = 0.
- Timeline, with cycle 0 = accept edge:
  - ACT is driven in cycle 1.
  - CAS is driven in cycle C = 1 + T_RCD.
  - Every non-command cycle drives DES.
- Write strobe: wdata_go pulses in cycle C + T_CWL - 1.
- Read strobe: rdata_exp pulses in cycle C + T_CL.
- PRE cycle P = max(Pa, 1 + T_RAS), where:
  - write: Pa = C + T_CWL + BL/2 + T_WR, with BL/2 = 4 for BL8 and 2 for BC4;
  - read: Pa = C + T_RTP.
- req_ready reasserts in cycle P + T_RP. Back-to-back accept in that cycle gives the next ACT at P + T_RP + 1.
- FSM states: IDLE, ACT, WAIT_RCD, CAS, WAIT_PRE, PRE, WAIT_RP.
  - IDLE to ACT on accept.
  - ACT to WAIT_RCD.
  - WAIT_RCD to CAS when the counter expires.
  - CAS to WAIT_PRE.
  - WAIT_PRE to PRE when both the data-recovery counter and the tRAS counter have expired.
  - PRE to WAIT_RP.
  - WAIT_RP to IDLE, with req_ready high in the final cycle.
- The tRAS counter starts at ACT and runs concurrently with the other counters.
- Counters saturate at 0 and never wrap. Parameters must keep every gap below 2^CNT_W.
- Reset mid-transaction aborts immediately: pins go to DES and no PRE is issued. The memory model clears its address queues on reset, so no pairing is lost.

Test Plan:
- Reset with req_valid=1 held → pins DES, req_ready=0 during reset; req_ready=1 one edge after release; accept on the following edge.
- Write, BL8, row=0x1_2345, col=0x2A0 accepted at cycle 0:
  - ACT at 1 with {bg, ba}=0x2, a14..a0=0x2345;
  - WR 01100 at 5 with addr9_0=0x2A0, bc_n_a12=1;
  - wdata_go at 13; PRE at 30; req_ready at 34.
- Write, BC4, same addresses: bc_n_a12=0 at CAS; PRE at 29 (tRAS-bound, not data-bound); req_ready at 33.
- Read, BL8, accepted at 0: RD 01101 at 5; rdata_exp at 16; PRE at 29 (tRAS-bound); req_ready at 33.
- Back-to-back write-then-read with req_valid held high: second ACT exactly at cycle 35, DES in every gap cycle, and the DIMM model returns the written data.
- Assert reset_n=0 at cycle 7 of a write → pins DES within the same cycle, no PRE; after release a new read completes normally.

Source files
------------

// File: rtl/ddr_cmd_driver.sv
// ---------------------------------------------------------------------------
// ddr_cmd_driver
//
// Controller-side DDR4 command generator. Accepts one transaction at a time
// and drives ACT -> RD/WR -> PRE on the command/address pins, inserting DES
// in every other cycle, plus the write-launch and read-expect data strobes.
//
// Handshake: a request transfers on a rising clock edge where req_valid and
// req_ready are both high; all request fields are captured on that edge,
// req_ready is low from the next cycle until the transaction has finished
// its precharge period, and inputs are ignored while req_ready is low.
//
// Ports:
//   clock_t, reset_n          clock, asynchronous active-low reset
//   req_valid/req_ready       request handshake
//   req_write                 1 = write, 0 = read
//   req_row[18:0]             {bg[1:0], ba[1:0], row[14:0]}
//   req_col[9:0]              column address
//   req_bl8                   1 = BL8, 0 = BC4
//   cs_n, act_n, ras_n_a16,
//   cas_n_a15, we_n_a14       command pins
//   bg_addr, ba_addr          bank group / bank
//   addr13, bc_n_a12, addr11,
//   ap_a10, addr9_0           address pins
//   wdata_go                  pulse: write burst starts next cycle
//   rdata_exp                 pulse: read data due on the bus
//   busy                      transaction in flight
//
// Cycle numbering: cycle 0 is the cycle in which the request is accepted
// (the transfer happens at its closing edge). Every output is registered and
// is decoded from the next state, so the pins always show the command of the
// state the FSM is in during that cycle.
// ---------------------------------------------------------------------------
module ddr_cmd_driver #(
    parameter int T_RCD = 4,
    parameter int T_CL  = 11,
    parameter int T_CWL = 9,
    parameter int T_WR  = 12,
    parameter int T_RTP = 6,
    parameter int T_RAS = 28,
    parameter int T_RP  = 4,
    parameter int CNT_W = 8
) (
    input  logic        clock_t,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [18:0] req_row,
    input  logic [9:0]  req_col,
    input  logic        req_bl8,
    output logic        cs_n,
    output logic        act_n,
    output logic        ras_n_a16,
    output logic        cas_n_a15,
    output logic        we_n_a14,
    output logic [1:0]  bg_addr,
    output logic [1:0]  ba_addr,
    output logic        addr13,
    output logic        bc_n_a12,
    output logic        addr11,
    output logic        ap_a10,
    output logic [9:0]  addr9_0,
    output logic        wdata_go,
    output logic        rdata_exp,
    output logic        busy
);

    // FSM encoding
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ACT      = 3'd1;
    localparam logic [2:0] S_WAIT_RCD = 3'd2;
    localparam logic [2:0] S_CAS      = 3'd3;
    localparam logic [2:0] S_WAIT_PRE = 3'd4;
    localparam logic [2:0] S_PRE      = 3'd5;
    localparam logic [2:0] S_WAIT_RP  = 3'd6;

    // Command encodings {cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14}
    localparam logic [4:0] CMD_DES = 5'b11111;
    localparam logic [4:0] CMD_WR  = 5'b01100;
    localparam logic [4:0] CMD_RD  = 5'b01101;
    localparam logic [4:0] CMD_PRE = 5'b01010;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Counter load values. A counter loaded with N on the edge entering
    // cycle k reads zero in cycle k+N; the FSM leaves a wait state at the end
    // of the cycle where the counter reads zero, hence the "-1" terms.
    // ACT in cycle 1, CAS due in cycle 1+T_RCD.
    localparam logic [CNT_W-1:0] RCD_LOAD = CNT_W'(T_RCD - 1);
    // tRAS: PRE may not appear before cycle 1+T_RAS.
    localparam logic [CNT_W-1:0] RAS_LOAD = CNT_W'(T_RAS - 1);
    // Data recovery, loaded entering the CAS cycle C; PRE due at C+gap.
    localparam logic [CNT_W-1:0] WR8_LOAD = CNT_W'(T_CWL + 4 + T_WR - 1);
    localparam logic [CNT_W-1:0] WR4_LOAD = CNT_W'(T_CWL + 2 + T_WR - 1);
    localparam logic [CNT_W-1:0] RTP_LOAD = CNT_W'(T_RTP - 1);
    // Strobe counters: pulse emitted in cycle C+load.
    localparam logic [CNT_W-1:0] CWL_LOAD = CNT_W'(T_CWL - 1);
    localparam logic [CNT_W-1:0] CL_LOAD  = CNT_W'(T_CL);
    // Precharge period: WAIT_RP occupies T_RP cycles after PRE.
    localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(T_RP - 1);

    function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_ONE;
    endfunction

    // State and counters (state is visible for checker binding)
    logic [2:0]       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] tras_cnt, tras_next;
    logic [CNT_W-1:0] strb_cnt, strb_next;
    logic             strb_write, strb_write_next;

    // Captured request
    logic        lat_write, write_next;
    logic [18:0] lat_row, row_next;
    logic [9:0]  lat_col, col_next;
    logic        lat_bl8, bl8_next;

    logic accept;
    logic take;
    logic ready_next;

    // Pin values for the next cycle
    logic [4:0]  cmd_next;
    logic [3:0]  bgba_next;
    logic [13:0] a_next;     // {addr13, bc_n_a12, addr11, ap_a10, addr9_0}

    assign accept = req_valid && req_ready;

    always_comb begin
        state_next      = state;
        cnt_next        = dec_sat(cnt);
        tras_next       = dec_sat(tras_cnt);
        strb_next       = dec_sat(strb_cnt);
        strb_write_next = strb_write;
        write_next      = lat_write;
        row_next        = lat_row;
        col_next        = lat_col;
        bl8_next        = lat_bl8;
        take            = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    take = 1'b1;
                end
            end
            S_ACT: begin
                state_next = S_WAIT_RCD;
            end
            S_WAIT_RCD: begin
                if (cnt == '0) begin
                    state_next      = S_CAS;
                    cnt_next        = lat_write ? (lat_bl8 ? WR8_LOAD : WR4_LOAD)
                                                : RTP_LOAD;
                    strb_next       = lat_write ? CWL_LOAD : CL_LOAD;
                    strb_write_next = lat_write;
                end
            end
            S_CAS: begin
                state_next = S_WAIT_PRE;
            end
            S_WAIT_PRE: begin
                // PRE needs both data recovery and tRAS satisfied
                if ((cnt == '0) && (tras_cnt == '0)) begin
                    state_next = S_PRE;
                end
            end
            S_PRE: begin
                state_next = S_WAIT_RP;
                cnt_next   = RP_LOAD;
            end
            S_WAIT_RP: begin
                // req_ready is already high in the last WAIT_RP cycle, so a
                // waiting request goes straight to ACT.
                if (cnt == '0) begin
                    if (accept) begin
                        take = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (take) begin
            state_next = S_ACT;
            write_next = req_write;
            row_next   = req_row;
            col_next   = req_col;
            bl8_next   = req_bl8;
            cnt_next   = RCD_LOAD;
            tras_next  = RAS_LOAD;
        end
    end

    assign ready_next = (state_next == S_IDLE) ||
                        ((state_next == S_WAIT_RP) && (cnt_next == '0));

    // Pin decode from the next state. The 15-bit row occupies a14..a0, so
    // the a16/a15 row bits carried on ras_n/cas_n during ACT are zero.
    always_comb begin
        cmd_next  = CMD_DES;
        bgba_next = 4'h0;
        a_next    = 14'h0;
        case (state_next)
            S_ACT: begin
                cmd_next  = {4'b0000, row_next[14]};
                bgba_next = row_next[18:15];
                a_next    = row_next[13:0];
            end
            S_CAS: begin
                cmd_next  = write_next ? CMD_WR : CMD_RD;
                bgba_next = row_next[18:15];
                a_next    = {1'b0, bl8_next, 1'b0, 1'b0, col_next};
            end
            S_PRE: begin
                cmd_next  = CMD_PRE;
                bgba_next = row_next[18:15];
                a_next    = 14'h0;     // ap_a10 = 0: single-bank precharge
            end
            default: begin
                cmd_next  = CMD_DES;
                bgba_next = 4'h0;
                a_next    = 14'h0;
            end
        endcase
    end

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            tras_cnt   <= '0;
            strb_cnt   <= '0;
            strb_write <= 1'b0;
            lat_write  <= 1'b0;
            lat_row    <= '0;
            lat_col    <= '0;
            lat_bl8    <= 1'b0;
            req_ready  <= 1'b0;
            busy       <= 1'b0;
            wdata_go   <= 1'b0;
            rdata_exp  <= 1'b0;
            {cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14} <= CMD_DES;
            {bg_addr, ba_addr} <= 4'h0;
            {addr13, bc_n_a12, addr11, ap_a10, addr9_0} <= 14'h0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            tras_cnt   <= tras_next;
            strb_cnt   <= strb_next;
            strb_write <= strb_write_next;
            lat_write  <= write_next;
            lat_row    <= row_next;
            lat_col    <= col_next;
            lat_bl8    <= bl8_next;
            req_ready  <= ready_next;
            busy       <= ~ready_next;
            // Strobe counter reads one in the cycle before the pulse cycle
            wdata_go   <= (strb_cnt == CNT_ONE) && strb_write;
            rdata_exp  <= (strb_cnt == CNT_ONE) && !strb_write;
            {cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14} <= cmd_next;
            {bg_addr, ba_addr} <= bgba_next;
            {addr13, bc_n_a12, addr11, ap_a10, addr9_0} <= a_next;
        end
    end

endmodule
